// File: rtl/adler32_byte_feeder.sv
// adler32_byte_feeder
//   Upstream stage of the adler32 checksum engine. Accepts 32-bit message
//   words over a valid/ready handshake and serialises them big-endian into
//   the engine's byte stream, one byte per clock. After the final byte of
//   each message it forces an idle gap of IDLE_GAP cycles (data_valid=0,
//   counted up to the next message's first byte) so the engine can latch
//   its checksum and re-initialise.
//
// Parameters
//   IDLE_GAP   idle cycles between last_data and the next message (1..15,
//              0 behaves as 1)
//
// Ports
//   clock       in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   upstream word valid
//   in_ready    out  feeder can accept a word this cycle (combinational)
//   in_data     in   message word, byte 0 = in_data[31:24]
//   in_last     in   word is the final word of the message
//   in_bytes    in   valid bytes in a final word (1..4, 0 or >4 means 4)
//   data_valid  out  byte valid to engine (registered)
//   data        out  byte to engine (registered)
//   last_data   out  final byte of message (registered)
//   busy        out  high while in SHIFT or GAP (registered)

module adler32_byte_feeder #(
  parameter int IDLE_GAP = 1
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        data_valid,
  output logic [7:0]  data,
  output logic        last_data,
  output logic        busy
);

  localparam int GAP_EFF = (IDLE_GAP < 1) ? 1 : ((IDLE_GAP > 15) ? 15 : IDLE_GAP);

  // The last_data cycle already lives in GAP and the IDLE cycle that accepts
  // the next word is itself idle, so GAP only needs to hold for GAP_EFF
  // cycles including the last_data cycle; the counter starts at GAP_EFF-1.
  localparam logic [3:0] GAP_LOAD = 4'(GAP_EFF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] hold_data;
  logic        hold_last;
  logic [2:0]  hold_bytes;
  logic [2:0]  idx;
  logic [2:0]  idx_inc;
  logic [3:0]  gap_cnt;

  logic [2:0]  eff_bytes;
  logic        accept;
  logic        word_done;
  logic        advance;
  logic        next_is_final;

  logic        dv_next;
  logic [7:0]  data_next;
  logic        last_next;

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

  // Non-final words always carry 4 bytes; out-of-range counts on a final
  // word are treated as a full word.
  always_comb begin
    eff_bytes = 3'd4;
    if (in_last && (in_bytes >= 3'd1) && (in_bytes <= 3'd4)) begin
      eff_bytes = in_bytes;
    end
  end

  // idx is the index of the byte currently on the output; word_done means
  // that byte is the word's last one (or the word finished and we are
  // waiting at a boundary with data_valid low).
  assign idx_inc       = idx + 3'd1;
  assign word_done     = (idx_inc == hold_bytes);
  assign next_is_final = ((idx_inc + 3'd1) == hold_bytes);
  assign advance       = (state == SHIFT) && !word_done;

  // Ready only when idle or at the boundary of a non-final word.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = word_done && !hold_last;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a message moves to GAP on the same edge that puts its
  // final byte on the output.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, SHIFT: begin
        if (accept) begin
          state_next = (in_last && (eff_bytes == 3'd1)) ? GAP : SHIFT;
        end else if (advance && hold_last && next_is_final) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered byte-stream outputs; data keeps its last
  // value when nothing is emitted.
  always_comb begin
    dv_next   = 1'b0;
    data_next = data;
    last_next = 1'b0;
    if (accept) begin
      dv_next   = 1'b1;
      data_next = in_data[31:24];
      last_next = in_last && (eff_bytes == 3'd1);
    end else if (advance) begin
      dv_next   = 1'b1;
      data_next = pick_byte(hold_data, idx_inc[1:0]);
      last_next = hold_last && next_is_final;
    end
  end

  // Holding register, byte index, gap counter and registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= 32'h0;
      hold_last  <= 1'b0;
      hold_bytes <= 3'd0;
      idx        <= 3'd0;
      gap_cnt    <= 4'd0;
      data_valid <= 1'b0;
      data       <= 8'h00;
      last_data  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (accept) begin
        hold_data  <= in_data;
        hold_last  <= in_last;
        hold_bytes <= eff_bytes;
        idx        <= 3'd0;
      end else if (advance) begin
        idx <= idx_inc;
      end

      if ((state_next == GAP) && (state != GAP)) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end

      data_valid <= dv_next;
      data       <= data_next;
      last_data  <= last_next;
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_adler32_byte_feeder.sv
// tb_adler32_byte_feeder
//   Scoreboard bench for adler32_byte_feeder. Messages are built as byte
//   lists, split into words by the driver, and the expected byte stream and
//   Adler-32 checksum of each message are queued when words/messages are
//   issued. A monitor on the falling edge pops and compares every byte the
//   DUT presents, recomputes the checksum of each delivered message, and
//   measures bubbles inside messages and the idle gap between messages.

module tb_adler32_byte_feeder;

  localparam int IDLE_GAP = 3;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic        data_valid;
  logic [7:0]  data;
  logic        last_data;
  logic        busy;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] chk_q[$];
  logic [7:0]  rx[$];

  int checks = 0;
  int errors = 0;

  bit mon_off = 1'b0;
  bit after_last = 1'b0;
  bit in_msg = 1'b0;
  int idle_run = 0;
  int bubbles = 0;
  int last_gap = -1;
  int last_bubbles = -1;

  adler32_byte_feeder #(.IDLE_GAP(IDLE_GAP)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .data_valid (data_valid),
    .data       (data),
    .last_data  (last_data),
    .busy       (busy)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] adler32(input logic [7:0] m[$]);
    int unsigned a;
    int unsigned b;
    a = 1;
    b = 0;
    foreach (m[i]) begin
      a = (a + 32'(m[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends one message as a sequence of words. full_ib selects the in_bytes
  // value for a full final word (-1 = random alias of 4); stall_at names a
  // word after which in_valid drops for 5 cycles at the word boundary.
  task automatic applyStimulus(input logic [7:0] msg[$], input logic [31:0] chk,
                               input int full_ib, input int stall_at,
                               input bit rand_gaps, input bit drop_after);
    chk_q.push_back(chk);
    for (int w = 0; w * 4 < msg.size(); w++) begin
      int          rem;
      int          cnt;
      int          t;
      bit          last;
      logic [31:0] word;
      logic [2:0]  ib;
      rem  = msg.size() - w * 4;
      last = (rem <= 4);
      cnt  = last ? rem : 4;
      word = $urandom;
      for (int k = 0; k < cnt; k++) word[31 - 8 * k -: 8] = msg[w * 4 + k];
      if (!last)           ib = 3'($urandom_range(0, 7));
      else if (cnt < 4)    ib = 3'(cnt);
      else if (full_ib >= 0) ib = 3'(full_ib);
      else ib = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(4, 7));

      if (rand_gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
      end

      in_valid = 1'b1;
      in_data  = word;
      in_last  = last;
      in_bytes = ib;
      t = 0;
      while (!in_ready && t < 200) begin
        @(posedge clock); #1;
        t++;
      end
      if (!in_ready) begin
        checkOutput("in_ready timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clock);
      for (int k = 0; k < cnt; k++) begin
        exp_t e;
        e.b = msg[w * 4 + k];
        e.l = last && (k == cnt - 1);
        exp_q.push_back(e);
      end
      #1;
      in_data = $urandom;
      in_last = 1'($urandom);

      if (w == stall_at && !last) begin
        in_valid = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        for (int s = 0; s < 5; s++) begin
          @(posedge clock); #1;
          checkOutput("stall in_ready", 32'(in_ready), 32'd1);
          checkOutput("stall data_valid", 32'(data_valid), 32'd0);
        end
      end
    end
    if (drop_after) in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clock);
      t++;
    end
    repeat (IDLE_GAP + 2) @(posedge clock);
    #1;
    checkOutput("drain bytes", 32'(exp_q.size()), 32'd0);
    checkOutput("drain checksums", 32'(chk_q.size()), 32'd0);
  endtask

  // Monitor: byte-by-byte scoreboard, checksum per message, gap/bubble
  // measurement and handshake state during the post-message gap.
  always @(negedge clock) begin
    if (rst_n && !mon_off) begin
      if (last_data && !data_valid) checkOutput("last without valid", 32'd1, 32'd0);
      if (data_valid) begin
        if (after_last) last_gap = idle_run;
        after_last = 1'b0;
        if (!in_msg) begin
          in_msg  = 1'b1;
          bubbles = 0;
        end
        if (exp_q.size() == 0) begin
          checkOutput("unexpected byte", 32'(data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("byte", 32'(data), 32'(e.b));
          checkOutput("last_data", 32'(last_data), 32'(e.l));
        end
        rx.push_back(data);
        if (last_data) begin
          checkOutput("in_ready on last", 32'(in_ready), 32'd0);
          if (chk_q.size() == 0) begin
            checkOutput("unexpected message end", 32'd1, 32'd0);
          end else begin
            logic [31:0] c;
            c = chk_q.pop_front();
            checkOutput("checksum", adler32(rx), c);
          end
          rx.delete();
          last_bubbles = bubbles;
          in_msg     = 1'b0;
          after_last = 1'b1;
          idle_run   = 0;
        end
      end else begin
        if (in_msg) bubbles++;
        if (after_last) begin
          idle_run++;
          if (idle_run <= IDLE_GAP) begin
            checkOutput("gap in_ready", 32'(in_ready), (idle_run >= IDLE_GAP) ? 32'd1 : 32'd0);
            checkOutput("gap busy", 32'(busy), (idle_run >= IDLE_GAP) ? 32'd0 : 32'd1);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] msg[$];
    logic [7:0] msg2[$];
    string      wiki;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    wiki     = "Wikipedia";

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset data_valid", 32'(data_valid), 32'd0);
    checkOutput("reset data", 32'(data), 32'h00);
    checkOutput("reset last_data", 32'(last_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    $display("[TB] single-word message");
    msg = '{8'h57, 8'h69, 8'h6B, 8'h69};
    applyStimulus(msg, adler32(msg), 4, -1, 1'b0, 1'b1);
    waitDrain();
    checkOutput("single-word bubbles", 32'(last_bubbles), 32'd0);

    $display("[TB] Wikipedia");
    msg.delete();
    for (int i = 0; i < wiki.len(); i++) msg.push_back(wiki[i]);
    applyStimulus(msg, 32'h11E60398, -1, -1, 1'b0, 1'b1);
    waitDrain();
    checkOutput("wikipedia bubbles", 32'(last_bubbles), 32'd0);

    $display("[TB] back-to-back messages");
    msg2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    last_gap = -1;
    applyStimulus(msg, 32'h11E60398, -1, -1, 1'b0, 1'b0);
    applyStimulus(msg2, adler32(msg2), -1, -1, 1'b0, 1'b1);
    waitDrain();
    checkOutput("back-to-back gap", 32'(last_gap), 32'(IDLE_GAP));

    $display("[TB] in_bytes normalisation");
    msg = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    applyStimulus(msg, adler32(msg), 0, -1, 1'b0, 1'b1);
    applyStimulus(msg, adler32(msg), 7, -1, 1'b0, 1'b1);
    msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    applyStimulus(msg, adler32(msg), -1, -1, 1'b0, 1'b1);
    msg = '{8'hE5, 8'h3C};
    applyStimulus(msg, adler32(msg), -1, -1, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] upstream starvation");
    msg = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    applyStimulus(msg, adler32(msg), -1, 0, 1'b0, 1'b1);
    waitDrain();
    checkOutput("starvation bubbles", 32'(last_bubbles), 32'd5);

    $display("[TB] reset mid-message");
    mon_off  = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_last  = 1'b0;
    in_bytes = 3'd4;
    while (!in_ready) begin @(posedge clock); #1; end
    @(posedge clock); #3;
    checkOutput("pre-reset data_valid", 32'(data_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset data_valid", 32'(data_valid), 32'd0);
    checkOutput("mid-reset last_data", 32'(last_data), 32'd0);
    checkOutput("mid-reset busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    chk_q.delete();
    rx.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    after_last = 1'b0;
    in_msg     = 1'b0;
    idle_run   = 0;
    mon_off    = 1'b0;
    checkOutput("after reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("after reset busy", 32'(busy), 32'd0);
    msg.delete();
    for (int i = 0; i < wiki.len(); i++) msg.push_back(wiki[i]);
    applyStimulus(msg, 32'h11E60398, -1, -1, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] randomized messages");
    for (int m = 0; m < 30; m++) begin
      int len;
      msg.delete();
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      applyStimulus(msg, adler32(msg), -1, -1, 1'b1, 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adler32_byte_feeder.md
Name: adler32_byte_feeder

Overview:
- Upstream stage of the adler32 checksum engine: accepts 32-bit message words over a valid/ready handshake and serialises them into the engine's byte stream (data_valid, data, last_data).
- Bytes are sent big-endian, at one byte per clock when input is available.
- Inserts a mandatory idle gap after each message so the engine can latch checksum_valid and re-initialise its accumulators before the next message.

Parameters:
- IDLE_GAP, 1, number of idle cycles (data_valid=0) forced after each last_data byte; legal range 1..15; value 0 is illegal and behaves as 1.

Ports:
- clock  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  feeder can accept a word this cycle
- in_data  input  32  message word; byte 0 = in_data[31:24], byte 3 = in_data[7:0]
- in_last  input  1  word is the final word of the message
- in_bytes  input  3  valid bytes in a final word, 1..4; 0 or >4 means 4; ignored when in_last=0 (always 4)
- data_valid  output  1  byte valid to engine
- data  output  8  byte to engine
- last_data  output  1  final byte of message, qualified by data_valid
- busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset (async assert, sync release): state=IDLE; data_valid=0, data=8'h00, last_data=0, busy=0, in_ready=1; holding register, byte index and gap counter cleared.
- All outputs are registered except in_ready (combinational from state and index). A word is accepted on a rising edge where in_valid && in_ready.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: in_ready=1. On accept, load in_data, in_last and eff_bytes (normalised in_bytes, or 4 if not last). Same edge drives data=in_data[31:24] and data_valid=1, with last_data=1 iff eff_bytes=1 and in_last. Go to SHIFT, or to GAP if that byte was the last. Latency is 1 cycle from accept to first byte.
- SHIFT: each cycle emits the next byte (index 1..eff_bytes-1), data_valid=1.
  - in_ready=1 only in the cycle where the current output byte is the final byte of a non-last word. An accept in that cycle loads the next word, and its byte 0 follows with no bubble.
  - If no word is accepted at a word boundary, data_valid=0 and the FSM waits in SHIFT with in_ready=1 (message still open; no last_data).
  - After emitting the final byte of a last word (last_data=1), go to GAP.
- GAP: data_valid=0, last_data=0, in_ready=0 for exactly IDLE_GAP cycles counted from the cycle after last_data, then IDLE.
- last_data is asserted only with data_valid=1 and only on the final byte of a message. It is never asserted on an empty message; every message has at least 1 byte.
- Data, in_last and in_bytes are don't-care when in_valid=0. Holding-register contents are stable once accepted; upstream may change inputs freely.
- in_ready=0 at any other time; in_valid held meanwhile must not cause an accept.
- Reset mid-message: all outputs drop within the reset assertion. The partial message is discarded; the engine shares rst_n and also clears.
- Byte stream throughput: 1 byte/cycle sustained across words; per-message overhead is exactly IDLE_GAP cycles.

Test Plan:
- Single-word message: in_data=32'h57696B69, in_last=1, in_bytes=4 -> bytes 57,69,6B,69 on 4 consecutive cycles starting 1 cycle after accept; last_data only on the 69 (4th byte); then 1 idle cycle; in_ready=0 from accept until IDLE.
- Multi-word "Wikipedia": words 57696B69, 70656469, 61xxxxxx (last, in_bytes=1), in_valid held -> 9 contiguous bytes, no bubbles, last_data on byte 61; downstream engine checksum=32'h11E60398 with checksum_valid=1.
- Back-to-back messages with IDLE_GAP=3, in_valid continuously high -> exactly 3 data_valid=0 cycles between last_data and the next message's first byte; both checksums correct.
- Normalisation: final word in_bytes=0 and in_bytes=7 -> 4 bytes emitted in each case; in_bytes=2 -> 2 bytes (in_data[31:24], [23:16]), last_data on the 2nd.
- Upstream starvation: in_valid dropped for 5 cycles at a word boundary mid-message -> data_valid=0 for those cycles, no last_data, in_ready=1; stream resumes with the correct next byte, and the checksum is unchanged versus the no-stall run.
- Async reset asserted mid-SHIFT (between clock edges) -> data_valid, last_data, busy fall immediately; after release in_ready=1, IDLE; a fresh message produces the correct checksum.
